// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: the four control-token codewords, the 2-bit
// control code type and the symbol-alignment FSM state type.
// Used by the channel decoder, the symbol decoder and the encoder.
package tmds_pkg;

  // Control tokens, written bit9..bit0; bit 0 is the first bit on the wire.
  localparam logic [9:0] TOKEN_CTRL0 = 10'b1101010100;
  localparam logic [9:0] TOKEN_CTRL1 = 10'b0010101011;
  localparam logic [9:0] TOKEN_CTRL2 = 10'b0101010100;
  localparam logic [9:0] TOKEN_CTRL3 = 10'b1010101011;

  // Control code {C1,C0}.
  typedef logic [1:0] ctrl_t;

  typedef enum logic [0:0] {
    StSearch,
    StLocked
  } lock_state_e;

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational TMDS symbol decoder.
// Ports:
//   sym      - 10-bit aligned symbol (bit 0 earliest)
//   is_token - 1 when sym is one of the four control tokens
//   ctrl     - control code for a token (00 when not a token)
//   data     - 8-bit pixel byte decoded from sym (meaningful for data symbols)
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [9:0] sym,
  output logic       is_token,
  output ctrl_t      ctrl,
  output logic [7:0] data
);

  logic [7:0] q;

  always_comb begin
    is_token = 1'b1;
    ctrl     = 2'b00;
    case (sym)
      TOKEN_CTRL0: ctrl = 2'b00;
      TOKEN_CTRL1: ctrl = 2'b01;
      TOKEN_CTRL2: ctrl = 2'b10;
      TOKEN_CTRL3: ctrl = 2'b11;
      default:     is_token = 1'b0;
    endcase
  end

  // bit 9 flags DC-balance inversion, bit 8 selects XOR (1) or XNOR (0) chaining.
  always_comb begin
    q       = sym[9] ? ~sym[7:0] : sym[7:0];
    data    = 8'h00;
    data[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      data[i] = sym[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
  end

endmodule

// File: rtl/tmds_channel_decoder.sv
// TMDS single-channel receiver: aligns an arbitrary-phase 10-bit word stream
// using runs of control tokens and decodes each symbol to pixel data or a
// control code.
// Ports:
//   clk_25mhz - pixel clock
//   reset     - synchronous, active-high
//   i_word    - raw deserialized word, bit 0 earliest
//   o_data    - decoded pixel byte (valid when o_de=1, held across tokens)
//   o_de      - 1 = data symbol, 0 = control token
//   o_ctrl    - decoded {C1,C0} (valid when o_de=0, held across data)
//   o_locked  - symbol alignment achieved
//   o_offset  - current bit offset 0..9
module tmds_channel_decoder
  import tmds_pkg::*;
#(
  parameter int unsigned LOCK_RUN      = 8,
  parameter int unsigned SEARCH_WINDOW = 1024,
  parameter int unsigned MAX_GAP       = 2048
) (
  input  logic       clk_25mhz,
  input  logic       reset,
  input  logic [9:0] i_word,
  output logic [7:0] o_data,
  output logic       o_de,
  output logic [1:0] o_ctrl,
  output logic       o_locked,
  output logic [3:0] o_offset
);

  localparam int unsigned RunW = (LOCK_RUN > 1) ? $clog2(LOCK_RUN) : 1;
  localparam int unsigned WinW = (SEARCH_WINDOW > 1) ? $clog2(SEARCH_WINDOW) : 1;
  localparam int unsigned GapW = (MAX_GAP > 1) ? $clog2(MAX_GAP) : 1;

  localparam logic [RunW-1:0] RunLast = RunW'(LOCK_RUN - 1);
  localparam logic [WinW-1:0] WinLast = WinW'(SEARCH_WINDOW - 1);
  localparam logic [GapW-1:0] GapLast = GapW'(MAX_GAP - 1);

  logic [9:0]  prev_q;
  logic [19:0] window_shifted;
  logic [9:0]  sym;
  logic        is_token;
  ctrl_t       ctrl;
  logic [7:0]  data;

  lock_state_e     state_q;
  logic [3:0]      offset_q;
  logic [3:0]      offset_next;
  logic [RunW-1:0] run_q;
  logic [WinW-1:0] win_q;
  logic [GapW-1:0] gap_q;

  // Symbol at offset k is {i_word, prev}[k+9:k].
  assign window_shifted = {i_word, prev_q} >> offset_q;
  assign sym            = window_shifted[9:0];
  assign offset_next    = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;

  tmds_symbol_decode u_symbol_decode (
    .sym      (sym),
    .is_token (is_token),
    .ctrl     (ctrl),
    .data     (data)
  );

  // Decode path runs regardless of lock; consumers qualify with o_locked.
  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      prev_q <= 10'd0;
      o_data <= 8'd0;
      o_de   <= 1'b0;
      o_ctrl <= 2'b00;
    end else begin
      prev_q <= i_word;
      o_de   <= ~is_token;
      if (is_token) begin
        o_ctrl <= ctrl;
      end else begin
        o_data <= data;
      end
    end
  end

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      state_q  <= StSearch;
      offset_q <= 4'd0;
      run_q    <= '0;
      win_q    <= '0;
      gap_q    <= '0;
    end else begin
      case (state_q)
        StSearch: begin
          // Lock takes priority over window expiry so the offset stays put.
          if (is_token && (run_q == RunLast)) begin
            state_q <= StLocked;
            run_q   <= '0;
            win_q   <= '0;
            gap_q   <= '0;
          end else if (win_q == WinLast) begin
            offset_q <= offset_next;
            win_q    <= '0;
            run_q    <= '0;
          end else begin
            win_q <= win_q + WinW'(1);
            run_q <= is_token ? run_q + RunW'(1) : '0;
          end
        end
        StLocked: begin
          if (is_token) begin
            gap_q <= '0;
          end else if (gap_q == GapLast) begin
            state_q  <= StSearch;
            offset_q <= offset_next;
            run_q    <= '0;
            win_q    <= '0;
            gap_q    <= '0;
          end else begin
            gap_q <= gap_q + GapW'(1);
          end
        end
        default: state_q <= StSearch;
      endcase
    end
  end

  assign o_locked = (state_q == StLocked);
  assign o_offset = offset_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Scoreboard bench for tmds_channel_decoder: the stimulus process pushes
// hand-computed expectations tagged with the clock cycle they fall due; a
// monitor pops and compares them on the falling edge.
module tb_tmds_channel_decoder;

  localparam logic [9:0] TOK0 = 10'h354;

  localparam logic [4:0] M_DE  = 5'b00001;
  localparam logic [4:0] M_CT  = 5'b00010;
  localparam logic [4:0] M_DA  = 5'b00100;
  localparam logic [4:0] M_LK  = 5'b01000;
  localparam logic [4:0] M_OF  = 5'b10000;
  localparam logic [4:0] M_ALL = 5'b11111;

  logic       clk_25mhz;
  logic       reset;
  logic [9:0] i_word;
  logic [7:0] o_data;
  logic       o_de;
  logic [1:0] o_ctrl;
  logic       o_locked;
  logic [3:0] o_offset;

  int cyc = 0;
  int n_checks = 0;
  int n_err = 0;

  typedef struct {
    int         due;
    logic [4:0] mask;
    logic       de;
    logic [1:0] ctrl;
    logic [7:0] data;
    logic       locked;
    logic [3:0] offset;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t cur;

  typedef struct packed {
    logic [9:0] w;
    logic       de;
    logic [1:0] ctrl;
    logic [7:0] data;
  } vec_t;

  // Locked at offset 0 after 0x354 tokens: ctrl 00, data last seen 0xFE.
  vec_t vecs [7] = '{
    '{10'h100, 1'b1, 2'b00, 8'h00},
    '{10'h200, 1'b1, 2'b00, 8'hFF},
    '{10'h2F0, 1'b1, 2'b00, 8'hEF},
    '{10'h1F0, 1'b1, 2'b00, 8'h10},
    '{10'h0AB, 1'b0, 2'b01, 8'h10},
    '{10'h154, 1'b0, 2'b10, 8'h10},
    '{10'h2AB, 1'b0, 2'b11, 8'h10}
  };

  tmds_channel_decoder dut (
    .clk_25mhz (clk_25mhz),
    .reset     (reset),
    .i_word    (i_word),
    .o_data    (o_data),
    .o_de      (o_de),
    .o_ctrl    (o_ctrl),
    .o_locked  (o_locked),
    .o_offset  (o_offset)
  );

  initial begin
    clk_25mhz = 1'b0;
    forever #5 clk_25mhz = ~clk_25mhz;
  end

  always @(posedge clk_25mhz) cyc <= cyc + 1;

  // Word that, repeated, presents token t aligned at bit offset (10-d)%10.
  function automatic logic [9:0] rot(input logic [9:0] t, input int d);
    logic [9:0] w;
    for (int b = 0; b < 10; b++) w[b] = t[(b + d) % 10];
    return w;
  endfunction

  task automatic push(input int due, input logic [4:0] mask, input logic de,
                      input logic [1:0] ctrl, input logic [7:0] data,
                      input logic locked, input logic [3:0] offset, input string name);
    exp_t e;
    e.due = due; e.mask = mask; e.de = de; e.ctrl = ctrl; e.data = data;
    e.locked = locked; e.offset = offset; e.name = name;
    sb.push_back(e);
  endtask

  task automatic step(input logic [9:0] w);
    i_word = w;
    @(posedge clk_25mhz);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk_25mhz) begin
    while (sb.size() != 0 && sb[0].due <= cyc) begin
      cur = sb.pop_front();
      if (cur.due < cyc) begin
        chk({cur.name, "_slot_missed"}, 8'(cyc), 8'(cur.due));
      end else begin
        if (cur.mask[0]) chk({cur.name, "_de"}, {7'd0, o_de}, {7'd0, cur.de});
        if (cur.mask[1]) chk({cur.name, "_ctrl"}, {6'd0, o_ctrl}, {6'd0, cur.ctrl});
        if (cur.mask[2]) chk({cur.name, "_data"}, o_data, cur.data);
        if (cur.mask[3]) chk({cur.name, "_locked"}, {7'd0, o_locked}, {7'd0, cur.locked});
        if (cur.mask[4]) chk({cur.name, "_offset"}, {4'd0, o_offset}, {4'd0, cur.offset});
      end
    end
  end

  initial begin
    int base;
    logic [9:0] w3;
    w3     = rot(TOK0, 7);
    reset  = 1'b1;
    i_word = TOK0;
    repeat (3) @(posedge clk_25mhz);
    #1;
    push(cyc, M_ALL, 1'b0, 2'b00, 8'h00, 1'b0, 4'd0, "in_reset");
    step(TOK0);

    // Release: first decode sees cleared prev (0x000 -> 0xFE), then tokens.
    base  = cyc;
    reset = 1'b0;
    push(base + 1, M_DE | M_DA | M_LK, 1'b1, 2'b00, 8'hFE, 1'b0, 4'd0, "rel_zero_sym");
    push(base + 2, M_DE | M_CT | M_DA, 1'b0, 2'b00, 8'hFE, 1'b0, 4'd0, "first_tok");
    push(base + 8, M_LK, 1'b0, 2'b00, 8'h00, 1'b0, 4'd0, "prelock0");
    push(base + 9, M_ALL, 1'b0, 2'b00, 8'hFE, 1'b1, 4'd0, "lock0");
    repeat (12) step(TOK0);

    // Directed data/control symbols while locked at offset 0.
    foreach (vecs[i]) begin
      push(cyc + 2, M_ALL, vecs[i].de, vecs[i].ctrl, vecs[i].data, 1'b1, 4'd0,
           $sformatf("vec%0d", i));
      step(vecs[i].w);
    end

    // 2048 data symbols without a token drop lock, then offset-1 tokens relock.
    base = cyc;
    push(base + 2048, M_LK | M_OF, 1'b0, 2'b00, 8'h00, 1'b1, 4'd0, "gap_hold");
    push(base + 2049, M_LK | M_OF | M_DE, 1'b1, 2'b00, 8'h00, 1'b0, 4'd1, "gap_drop");
    push(base + 2056, M_LK, 1'b0, 2'b00, 8'h00, 1'b0, 4'd1, "prelock1");
    push(base + 2057, M_LK | M_OF | M_DE | M_CT, 1'b0, 2'b00, 8'h00, 1'b1, 4'd1, "lock1");
    repeat (2048) step(10'h100);
    repeat (12) step(rot(TOK0, 9));

    // Data mid-line at offset 1, then reset while locked.
    base = cyc;
    push(base + 3, M_DE | M_DA | M_LK | M_OF, 1'b1, 2'b00, 8'h10, 1'b1, 4'd1, "midline");
    repeat (3) step(rot(10'h1F0, 9));
    reset = 1'b1;
    push(cyc + 1, M_ALL, 1'b0, 2'b00, 8'h00, 1'b0, 4'd0, "rst_mid");
    repeat (2) step(w3);

    // Search from offset 0 over a stream aligned at offset 3.
    base  = cyc;
    reset = 1'b0;
    push(base + 1023, M_LK | M_OF, 1'b0, 2'b00, 8'h00, 1'b0, 4'd0, "srch_off0");
    push(base + 1024, M_LK | M_OF, 1'b0, 2'b00, 8'h00, 1'b0, 4'd1, "srch_off1");
    push(base + 2047, M_OF, 1'b0, 2'b00, 8'h00, 1'b0, 4'd1, "srch_off1_end");
    push(base + 2048, M_LK | M_OF, 1'b0, 2'b00, 8'h00, 1'b0, 4'd2, "srch_off2");
    push(base + 3072, M_LK | M_OF, 1'b0, 2'b00, 8'h00, 1'b0, 4'd3, "srch_off3");
    push(base + 3079, M_LK, 1'b0, 2'b00, 8'h00, 1'b0, 4'd3, "prelock3");
    push(base + 3080, M_LK | M_OF | M_DE | M_CT, 1'b0, 2'b00, 8'h00, 1'b1, 4'd3, "lock3");
    repeat (3090) step(w3);

    for (int i = 0; i < 8 && sb.size() != 0; i++) @(posedge clk_25mhz);
    #1;
    while (sb.size() != 0) begin
      cur = sb.pop_front();
      chk({cur.name, "_never_checked"}, 8'd1, 8'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
